// File: rtl/simt_reconv_stack_pkg.sv
// Shared types and constants for the per-warp SIMT reconvergence stack.
package simt_reconv_stack_pkg;

   localparam int WARP_SIZE        = 32;
   localparam int SIMT_STACK_DEPTH = 8;
   localparam int SIMT_PC_WIDTH    = 32;

   typedef logic [WARP_SIZE-1:0] warp_mask_t;

   // One nested divergence: where to reconverge, what to restore there,
   // and the still-unexecuted fall-through path.
   typedef struct packed {
      logic [SIMT_PC_WIDTH-1:0] rpc;
      warp_mask_t               orig_mask;
      logic [SIMT_PC_WIDTH-1:0] pend_pc;
      warp_mask_t               pend_mask;
      logic                     pend_vld;
   } simt_stack_entry_t;

endpackage

// File: rtl/simt_reconv_stack_if.sv
// Branch-unit / scheduler facing bundle of the reconvergence stack.
interface simt_reconv_stack_if
   import simt_reconv_stack_pkg::*;
#(
   parameter int PC_WIDTH = SIMT_PC_WIDTH,
   parameter int DEPTH_W  = $clog2(SIMT_STACK_DEPTH + 1)
);
   logic                 warp_start;
   warp_mask_t           start_mask;
   logic                 div_valid;
   logic                 is_divergent;
   warp_mask_t           taken_mask;
   warp_mask_t           not_taken_mask;
   logic [PC_WIDTH-1:0]  target_pc;
   logic [PC_WIDTH-1:0]  fallthrough_pc;
   logic [PC_WIDTH-1:0]  reconv_pc;
   logic                 sync_valid;
   logic [PC_WIDTH-1:0]  sync_pc;

   warp_mask_t           active_mask;
   logic                 redirect_valid;
   logic [PC_WIDTH-1:0]  redirect_pc;
   logic                 reconverged;
   logic [DEPTH_W-1:0]   depth;
   logic                 stack_full;
   logic                 stack_empty;
   logic                 overflow_err;

   // Branch unit / scheduler side.
   modport master (
      output warp_start, start_mask, div_valid, is_divergent, taken_mask,
             not_taken_mask, target_pc, fallthrough_pc, reconv_pc,
             sync_valid, sync_pc,
      input  active_mask, redirect_valid, redirect_pc, reconverged, depth,
             stack_full, stack_empty, overflow_err
   );

   // Reconvergence stack side.
   modport slave (
      input  warp_start, start_mask, div_valid, is_divergent, taken_mask,
             not_taken_mask, target_pc, fallthrough_pc, reconv_pc,
             sync_valid, sync_pc,
      output active_mask, redirect_valid, redirect_pc, reconverged, depth,
             stack_full, stack_empty, overflow_err
   );

endinterface

// File: rtl/simt_reconv_stack.sv
// Per-warp reconvergence stack: serialises taken / fall-through paths of a
// divergent branch and restores the pre-branch mask at the post-dominator.
module simt_reconv_stack
   import simt_reconv_stack_pkg::*;
#(
   parameter int STACK_DEPTH = SIMT_STACK_DEPTH,
   parameter int PC_WIDTH    = SIMT_PC_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   simt_reconv_stack_if.slave  bus
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   // Entry PCs are stored at the package width; PC_WIDTH is expected to match.
   simt_stack_entry_t   stack_mem [STACK_DEPTH];
   simt_stack_entry_t   top;

   warp_mask_t          active_q,  active_nxt;
   logic [DEPTH_W-1:0]  depth_q,   depth_nxt;
   logic                rv_q,      rv_nxt;
   logic [PC_WIDTH-1:0] rpc_q,     rpc_nxt;
   logic                recon_q,   recon_nxt;
   logic                full_q,    empty_q;
   logic                ovf_q,     ovf_nxt;

   logic                full;
   logic                empty;
   logic [IDX_W-1:0]    top_idx;
   logic [IDX_W-1:0]    push_idx;
   logic                do_push;
   logic                do_pend_clr;

   assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign empty    = (depth_q == '0);
   assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));
   assign push_idx = IDX_W'(depth_q);
   // Top-of-stack is a combinational read; only meaningful when not empty.
   assign top      = stack_mem[top_idx];

   // Next-state decode: warp_start > divergence > sync, lower ones dropped.
   always_comb begin
      active_nxt  = active_q;
      depth_nxt   = depth_q;
      rv_nxt      = 1'b0;
      rpc_nxt     = rpc_q;
      recon_nxt   = 1'b0;
      ovf_nxt     = ovf_q;
      do_push     = 1'b0;
      do_pend_clr = 1'b0;
      if (bus.warp_start) begin
         active_nxt = bus.start_mask;
         depth_nxt  = '0;
      end else if (bus.div_valid) begin
         // A uniform branch still owns this cycle's event slot.
         if (bus.is_divergent) begin
            if (full) begin
               ovf_nxt = 1'b1;
            end else begin
               do_push    = 1'b1;
               active_nxt = bus.taken_mask;
               depth_nxt  = depth_q + DEPTH_W'(1);
               rv_nxt     = 1'b1;
               rpc_nxt    = bus.target_pc;
            end
         end
      end else if (bus.sync_valid && !empty &&
                   (SIMT_PC_WIDTH'(bus.sync_pc) == top.rpc)) begin
         if (top.pend_vld) begin
            // Switch to the deferred fall-through path.
            do_pend_clr = 1'b1;
            active_nxt  = top.pend_mask;
            rv_nxt      = 1'b1;
            rpc_nxt     = PC_WIDTH'(top.pend_pc);
         end else begin
            // Both paths done: warp simply continues at the reconv PC.
            active_nxt = top.orig_mask;
            depth_nxt  = depth_q - DEPTH_W'(1);
            recon_nxt  = 1'b1;
         end
      end
   end

   // Architectural state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= '0;
         depth_q  <= '0;
         rv_q     <= 1'b0;
         rpc_q    <= '0;
         recon_q  <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         active_q <= active_nxt;
         depth_q  <= depth_nxt;
         rv_q     <= rv_nxt;
         rpc_q    <= rpc_nxt;
         recon_q  <= recon_nxt;
         full_q   <= (depth_nxt == DEPTH_W'(STACK_DEPTH));
         empty_q  <= (depth_nxt == '0);
         ovf_q    <= ovf_nxt;
      end
   end

   // Entry storage; contents are don't-care out of reset, so no reset here.
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_mem[push_idx] <= '{
            rpc:       SIMT_PC_WIDTH'(bus.reconv_pc),
            orig_mask: active_q,
            pend_pc:   SIMT_PC_WIDTH'(bus.fallthrough_pc),
            pend_mask: bus.not_taken_mask,
            pend_vld:  1'b1
         };
      end else if (do_pend_clr) begin
         stack_mem[top_idx].pend_vld <= 1'b0;
      end
   end

   assign bus.active_mask    = active_q;
   assign bus.depth          = depth_q;
   assign bus.redirect_valid = rv_q;
   assign bus.redirect_pc    = rpc_q;
   assign bus.reconverged    = recon_q;
   assign bus.stack_full     = full_q;
   assign bus.stack_empty    = empty_q;
   assign bus.overflow_err   = ovf_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed self-checking bench for simt_reconv_stack.
module tb_simt_reconv_stack;
   import simt_reconv_stack_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] last_rpc = 32'h0;

   simt_reconv_stack_if bus ();

   simt_reconv_stack dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Snapshot: {active, rv, rpc, recon, depth, full, empty, ovf}
   logic [72:0] obs;
   assign obs = {bus.active_mask, bus.redirect_valid, bus.redirect_pc,
                 bus.reconverged, bus.depth, bus.stack_full,
                 bus.stack_empty, bus.overflow_err};

   task automatic idle();
      bus.warp_start     = 1'b0;
      bus.start_mask     = '0;
      bus.div_valid      = 1'b0;
      bus.is_divergent   = 1'b0;
      bus.taken_mask     = '0;
      bus.not_taken_mask = '0;
      bus.target_pc      = '0;
      bus.fallthrough_pc = '0;
      bus.reconv_pc      = '0;
      bus.sync_valid     = 1'b0;
      bus.sync_pc        = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_div(input logic [31:0] tk, input logic [31:0] nt,
                          input logic [31:0] tgt, input logic [31:0] fall,
                          input logic [31:0] rcv);
      bus.div_valid = 1'b1; bus.is_divergent = 1'b1;
      bus.taken_mask = tk; bus.not_taken_mask = nt;
      bus.target_pc = tgt; bus.fallthrough_pc = fall; bus.reconv_pc = rcv;
   endtask

   task automatic test_reset();
      logic [72:0] exp;
      idle();
      tick(); tick();
      exp = {32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL reset: got %h want %h", obs, exp);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_warp_start();
      logic [72:0] exp;
      bus.warp_start = 1'b1; bus.start_mask = 32'hFFFF_FFFF;
      tick(); idle();
      exp = {32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL warp_start: got %h want %h", obs, exp);
      end
   endtask

   task automatic test_divergence();
      logic [72:0] exp;
      set_div(32'h0000_FFFF, 32'hFFFF_0000, 32'h100, 32'h40, 32'h80);
      tick(); idle();
      exp = {32'h0000_FFFF, 1'b1, 32'h100, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL div_push: got %h want %h", obs, exp);
      end
      tick();
      exp = {32'h0000_FFFF, 1'b0, 32'h100, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL redirect_pulse: got %h want %h", obs, exp);
      end
      bus.sync_valid = 1'b1; bus.sync_pc = 32'h80;
      tick(); idle();
      exp = {32'hFFFF_0000, 1'b1, 32'h40, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL sync_pend: got %h want %h", obs, exp);
      end
      bus.sync_valid = 1'b1; bus.sync_pc = 32'h80;
      tick(); idle();
      exp = {32'hFFFF_FFFF, 1'b0, 32'h40, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL sync_pop: got %h want %h", obs, exp);
      end
      tick();
      checks++;
      if (bus.reconverged !== 1'b0) begin
         errors++; $display("FAIL reconv_pulse: got %b want 0", bus.reconverged);
      end
      last_rpc = 32'h40;
   endtask

   task automatic test_nested_overflow();
      logic [72:0] exp;
      logic [31:0] bit_i;
      for (int i = 0; i < 8; i++) begin
         bit_i = 32'h1 << i;
         set_div((32'hFFFF_FFFF << i) & ~bit_i, bit_i,
                 32'h2000 + i*16, 32'h3000 + i*16, 32'h4000 + i*16);
         tick(); idle();
         last_rpc = 32'h2000 + i*16;
         exp = {32'hFFFF_FFFF << (i+1), 1'b1, last_rpc, 1'b0, 4'(i+1),
                (i == 7), 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL nest_push%0d: got %h want %h", i, obs, exp);
         end
      end
      set_div(32'h0000_0F00, 32'h0000_F000, 32'h9000, 32'h9004, 32'h9008);
      tick(); idle();
      exp = {32'hFFFF_FF00, 1'b0, last_rpc, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL overflow: got %h want %h", obs, exp);
      end
      for (int i = 7; i >= 0; i--) begin
         bus.sync_valid = 1'b1; bus.sync_pc = 32'h4000 + i*16;
         tick(); idle();
         last_rpc = 32'h3000 + i*16;
         exp = {32'h1 << i, 1'b1, last_rpc, 1'b0, 4'(i+1), (i == 7), 1'b0, 1'b1};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL unwind_pend%0d: got %h want %h", i, obs, exp);
         end
         bus.sync_valid = 1'b1; bus.sync_pc = 32'h4000 + i*16;
         tick(); idle();
         exp = {32'hFFFF_FFFF << i, 1'b0, last_rpc, 1'b1, 4'(i), 1'b0,
                (i == 0), 1'b1};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL unwind_pop%0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_priority_and_ignored();
      logic [72:0] exp;
      bus.warp_start = 1'b1; bus.start_mask = 32'hFFFF_FFFF;
      tick(); idle();
      set_div(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h500, 32'h504, 32'h600);
      tick(); idle();
      // Push B while a sync matching A's rpc arrives: sync must be dropped.
      set_div(32'h0000_000F, 32'h0F0F_0F00, 32'h700, 32'h704, 32'h800);
      bus.sync_valid = 1'b1; bus.sync_pc = 32'h600;
      tick(); idle();
      exp = {32'h0000_000F, 1'b1, 32'h700, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL div_beats_sync: got %h want %h", obs, exp);
      end
      bus.sync_valid = 1'b1; bus.sync_pc = 32'h999;
      tick(); idle();
      exp = {32'h0000_000F, 1'b0, 32'h700, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL sync_mismatch: got %h want %h", obs, exp);
      end
      bus.sync_valid = 1'b1; bus.sync_pc = 32'h600;
      tick(); idle();
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL sync_not_top: got %h want %h", obs, exp);
      end
      bus.div_valid = 1'b1; bus.is_divergent = 1'b0;
      bus.taken_mask = 32'h1; bus.target_pc = 32'hBAD;
      tick(); idle();
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL uniform_branch: got %h want %h", obs, exp);
      end
      // warp_start wins over a simultaneous divergence.
      set_div(32'h1, 32'h2, 32'hC00, 32'hC04, 32'hC08);
      bus.warp_start = 1'b1; bus.start_mask = 32'hAAAA_AAAA;
      tick(); idle();
      exp = {32'hAAAA_AAAA, 1'b0, 32'h700, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL start_beats_div: got %h want %h", obs, exp);
      end
      bus.sync_valid = 1'b1; bus.sync_pc = 32'h800;
      tick(); idle();
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL sync_empty: got %h want %h", obs, exp);
      end
   endtask

   task automatic test_async_reset();
      logic [72:0] exp;
      for (int i = 0; i < 3; i++) begin
         set_div(32'h5555_5555, 32'h2222_2222, 32'hD00 + i, 32'hE00 + i, 32'hF00 + i);
         tick(); idle();
      end
      checks++;
      if (bus.depth !== 4'd3) begin
         errors++; $display("FAIL pre_reset_depth: got %0d want 3", bus.depth);
      end
      #2 rst_n = 1'b0;
      #1;
      exp = {32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL async_reset: got %h want %h", obs, exp);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_warp_start();
      test_divergence();
      test_nested_overflow();
      test_priority_and_ignored();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/simt_reconv_stack.md
Name: simt_reconv_stack

Overview:
Per-warp reconvergence stack. It consumes the divergence results of thread_mask_unit (is_divergent, taken_mask, not_taken_mask) and serialises the two branch paths. It restores the pre-branch mask at the immediate post-dominator. It sits between the branch unit and the warp scheduler/fetch stage. It drives the warp's active mask and PC redirects.

Parameters:
STACK_DEPTH, 8, number of nested divergence entries.
PC_WIDTH, 32, program counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
warp_start  in  1  load start_mask and clear the stack
start_mask  in  WARP_SIZE  initial active mask
div_valid  in  1  branch resolved this cycle
is_divergent  in  1  from thread_mask_unit
taken_mask  in  WARP_SIZE  active lanes that took the branch
not_taken_mask  in  WARP_SIZE  active lanes that fell through
target_pc  in  PC_WIDTH  branch target
fallthrough_pc  in  PC_WIDTH  next sequential PC
reconv_pc  in  PC_WIDTH  immediate post-dominator PC
sync_valid  in  1  warp reached a SYNC/reconvergence instruction
sync_pc  in  PC_WIDTH  PC of that instruction
active_mask  out  WARP_SIZE  current warp active mask
redirect_valid  out  1  one-cycle pulse; fetch must jump to redirect_pc
redirect_pc  out  PC_WIDTH  redirect target
reconverged  out  1  one-cycle pulse when an entry is popped
depth  out  $clog2(STACK_DEPTH+1)  occupied entries
stack_full  out  1  depth == STACK_DEPTH
stack_empty  out  1  depth == 0
overflow_err  out  1  sticky error flag

Behaviour:
- Reset values: active_mask=0, depth=0, redirect_valid=0, redirect_pc=0, reconverged=0, overflow_err=0. The stack contents are don't-care.
- All outputs are registered. A decision is visible 1 cycle after the input event.
- Entry fields: rpc (reconv PC), orig_mask, pend_pc, pend_mask, pend_vld.
- Event priority per cycle: warp_start, then divergence, then sync. Lower-priority events in the same cycle are dropped.
- warp_start: active_mask<=start_mask; depth<=0; overflow_err unchanged.
- Divergence, when div_valid && is_divergent and not full:
  - push {rpc=reconv_pc, orig_mask=active_mask, pend_pc=fallthrough_pc, pend_mask=not_taken_mask, pend_vld=1};
  - active_mask<=taken_mask;
  - redirect_valid<=1, redirect_pc<=target_pc.
- Uniform branch, when div_valid && !is_divergent: no stack or mask change and no redirect. Fetch handles uniform branches.
- Divergence when full: no push, no mask change, no redirect; overflow_err<=1 (sticky until reset).
- Sync, when sync_valid && !empty && sync_pc==top.rpc:
  - If top.pend_vld: active_mask<=top.pend_mask; redirect to top.pend_pc; clear top.pend_vld. Depth is unchanged.
  - Else pop: active_mask<=top.orig_mask; depth--; reconverged<=1; no redirect, because the warp continues at reconv_pc.
- Sync with an empty stack, or with sync_pc != top.rpc: ignored, no state change.
- Nested divergence: inner entries push above outer entries. Pops proceed innermost-first. The mask restore is exact at each level.
- An asynchronous reset asserted mid-operation clears everything immediately, with no partial pops.

Decomposition:
- pkg_opengpu additions:
  - typedef simt_stack_entry_t {rpc, orig_mask, pend_pc, pend_mask, pend_vld};
  - SIMT_STACK_DEPTH constant.
- WARP_SIZE comes from pkg_opengpu.
- The stack storage is a small register array inside the module. No sub-module is required.
- The top-of-stack read is combinational from the depth-1 index.

Test Plan:
- Reset, then warp_start with mask FFFFFFFF -> active_mask=FFFFFFFF, depth=0, stack_empty=1.
- Divergent branch (taken=0000FFFF, not_taken=FFFF0000, target=0x100, fall=0x40, reconv=0x80) -> next cycle active=0000FFFF, redirect 0x100, depth=1.
- sync_pc=0x80 -> active=FFFF0000, redirect 0x40, depth=1. A second sync_pc=0x80 -> active=FFFFFFFF, reconverged pulse, depth=0, no redirect.
- Push 8 nested divergences, then a 9th -> stack_full=1, overflow_err=1, active_mask and depth unchanged. Subsequently, 16 matching syncs unwind the stack back to FFFFFFFF.
- div_valid and sync_valid in the same cycle -> only the push occurs. Sync with a mismatched PC, or on an empty stack, -> no change.
- Assert rst_n low at depth=3 -> all outputs return to their reset values asynchronously.
